// File: rtl/xor_lane_pipe_if.sv
// Stream bundle for xor_lane_pipe: input beat channel plus registered result channel.
// The master side is the producer/consumer pair around the block; slave is the block itself.
interface xor_lane_pipe_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 2
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_a;
  logic [LANES*WIDTH-1:0] in_b;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_c;
  logic                   out_last;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_c, out_last
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_c, out_last
  );
endinterface

// File: rtl/xor_lane_pipe.sv
// Multi-lane registered XOR combiner with a one-deep output register and an optional
// per-frame XOR-fold accumulator; disabled lanes are hard-wired to zero.
module xor_lane_pipe #(
  parameter int               WIDTH = 8,
  parameter int               LANES = 2,
  parameter logic [LANES-1:0] DOIT  = {LANES{1'b1}},
  parameter int               ACCUM = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  xor_lane_pipe_if.slave       bus,
  output logic [15:0]          beat_count
);
  localparam int DW = LANES * WIDTH;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   lane_r;
  logic [DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   out_c_q, out_c_d;
  logic            out_last_q, out_last_d;
  logic            acc_en;
  logic            pop;
  logic            produce;

  // Ready depends only on the output register and the consumer, never on in_valid.
  assign bus.in_ready = (state_q == EMPTY) || bus.out_ready;
  assign acc_en       = bus.in_valid && bus.in_ready;
  assign pop          = (state_q == FULL) && bus.out_ready;
  assign produce      = acc_en && ((ACCUM == 0) || bus.in_last);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_r[i*WIDTH +: WIDTH] = DOIT[i]
        ? (bus.in_a[i*WIDTH +: WIDTH] ^ bus.in_b[i*WIDTH +: WIDTH])
        : '0;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    out_c_d    = out_c_q;
    out_last_d = out_last_q;

    unique case (state_q)
      EMPTY:   if (produce)         state_d = FULL;
      FULL:    if (pop && !produce) state_d = EMPTY;
      default:                      state_d = EMPTY;
    endcase

    if (produce) begin
      // acc_q is identically zero in per-beat mode, so one expression serves both modes.
      out_c_d    = acc_q ^ lane_r;
      out_last_d = (ACCUM != 0) ? 1'b1 : bus.in_last;
    end

    if ((ACCUM != 0) && acc_en) begin
      acc_d = bus.in_last ? '0 : (acc_q ^ lane_r);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      acc_q      <= '0;
      out_c_q    <= '0;
      out_last_q <= 1'b0;
      beat_count <= 16'h0000;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      out_c_q    <= out_c_d;
      out_last_q <= out_last_d;
      if (acc_en) beat_count <= beat_count + 16'd1;
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_c     = out_c_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_xor_lane_pipe.sv
// Directed bench for xor_lane_pipe: per-beat mode (all lanes / lane 1 disabled) and
// frame-accumulate mode, driven in parallel from one linear stimulus sequence.
module tb_xor_lane_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] cnt0, cnt1, cnt2;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xor_lane_pipe_if #(.WIDTH(8), .LANES(2)) bus0 ();
  xor_lane_pipe_if #(.WIDTH(8), .LANES(2)) bus1 ();
  xor_lane_pipe_if #(.WIDTH(8), .LANES(2)) bus2 ();

  xor_lane_pipe #(.WIDTH(8), .LANES(2), .DOIT(2'b11), .ACCUM(0)) u_beat (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .beat_count(cnt0));
  xor_lane_pipe #(.WIDTH(8), .LANES(2), .DOIT(2'b01), .ACCUM(0)) u_mask (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .beat_count(cnt1));
  xor_lane_pipe #(.WIDTH(8), .LANES(2), .DOIT(2'b11), .ACCUM(1)) u_frame (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .beat_count(cnt2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Same beat offered to all three instances.
  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic last, input logic ordy);
    bus0.in_valid = v;  bus0.in_a = a;  bus0.in_b = b;  bus0.in_last = last;  bus0.out_ready = ordy;
    bus1.in_valid = v;  bus1.in_a = a;  bus1.in_b = b;  bus1.in_last = last;  bus1.out_ready = ordy;
    bus2.in_valid = v;  bus2.in_a = a;  bus2.in_b = b;  bus2.in_last = last;  bus2.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #2;
    check("rst_out_valid", {31'b0, bus0.out_valid}, 32'h0);
    check("rst_in_ready", {31'b0, bus0.in_ready}, 32'h1);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    #12;
    // Reset values
    check("reset_out_valid", {31'b0, bus0.out_valid}, 32'h0);
    check("reset_out_c", {16'b0, bus0.out_c}, 32'h0);
    check("reset_out_last", {31'b0, bus0.out_last}, 32'h0);
    check("reset_beat_count", {16'b0, cnt0}, 32'h0);
    check("reset_in_ready", {31'b0, bus0.in_ready}, 32'h1);
    check("reset_mask_out_c", {16'b0, bus1.out_c}, 32'h0);
    tick();
    rst_n = 1'b1;

    // Basic per-beat XOR, all lanes and lane 1 disabled
    drive(1'b1, 16'h3CA5, 16'h0FFF, 1'b0, 1'b1);
    #1 check("basic_in_ready", {31'b0, bus0.in_ready}, 32'h1);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    check("basic_out_c", {16'b0, bus0.out_c}, 32'h335A);
    check("basic_out_valid", {31'b0, bus0.out_valid}, 32'h1);
    check("basic_out_last", {31'b0, bus0.out_last}, 32'h0);
    check("basic_beat_count", {16'b0, cnt0}, 32'h1);
    check("mask_out_c", {16'b0, bus1.out_c}, 32'h005A);
    check("frame_nonlast_no_out", {31'b0, bus2.out_valid}, 32'h0);
    tick();
    check("basic_drain_valid", {31'b0, bus0.out_valid}, 32'h0);

    // Backpressure: three beats offered with consumer stalled
    do_reset();
    drive(1'b1, 16'h0011, 16'h0000, 1'b1, 1'b0);
    tick();
    drive(1'b1, 16'h0022, 16'h0000, 1'b0, 1'b0);
    #1;
    check("bp_in_ready_low", {31'b0, bus0.in_ready}, 32'h0);
    check("bp_first_out_c", {16'b0, bus0.out_c}, 32'h0011);
    tick();
    tick();
    check("bp_hold_out_c", {16'b0, bus0.out_c}, 32'h0011);
    check("bp_hold_out_last", {31'b0, bus0.out_last}, 32'h1);
    check("bp_hold_count", {16'b0, cnt0}, 32'h1);
    bus0.out_ready = 1'b1;
    #1 check("bp_in_ready_high", {31'b0, bus0.in_ready}, 32'h1);
    tick();
    check("bp_second_out_c", {16'b0, bus0.out_c}, 32'h0022);
    check("bp_second_last", {31'b0, bus0.out_last}, 32'h0);
    check("bp_second_valid", {31'b0, bus0.out_valid}, 32'h1);
    drive(1'b1, 16'h0033, 16'h0000, 1'b1, 1'b1);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    check("bp_third_out_c", {16'b0, bus0.out_c}, 32'h0033);
    check("bp_third_last", {31'b0, bus0.out_last}, 32'h1);
    tick();
    check("bp_empty", {31'b0, bus0.out_valid}, 32'h0);
    check("bp_count", {16'b0, cnt0}, 32'h3);

    // Frame accumulate: lane0 1^2^4 = 07, lane1 80^40^20 = E0
    do_reset();
    drive(1'b1, 16'h8001, 16'h0000, 1'b0, 1'b1);
    tick();
    check("acc_beat1_no_out", {31'b0, bus2.out_valid}, 32'h0);
    drive(1'b1, 16'h4002, 16'h0000, 1'b0, 1'b1);
    tick();
    check("acc_beat2_no_out", {31'b0, bus2.out_valid}, 32'h0);
    drive(1'b1, 16'h2004, 16'h0000, 1'b1, 1'b1);
    tick();
    check("acc_frame_out_c", {16'b0, bus2.out_c}, 32'hE007);
    check("acc_frame_valid", {31'b0, bus2.out_valid}, 32'h1);
    check("acc_frame_last", {31'b0, bus2.out_last}, 32'h1);
    check("acc_frame_count", {16'b0, cnt2}, 32'h3);
    drive(1'b1, 16'h0010, 16'h0000, 1'b1, 1'b1);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    check("acc_single_out_c", {16'b0, bus2.out_c}, 32'h0010);
    check("acc_single_valid", {31'b0, bus2.out_valid}, 32'h1);
    tick();
    check("acc_drain_valid", {31'b0, bus2.out_valid}, 32'h0);

    // Reset mid-frame, with a held output on the per-beat instance
    do_reset();
    drive(1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0002, 16'h0000, 1'b0, 1'b0);
    tick();
    check("mid_count_pre", {16'b0, cnt2}, 32'h2);
    check("mid_held_valid", {31'b0, bus0.out_valid}, 32'h1);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_drop_valid", {31'b0, bus0.out_valid}, 32'h0);
    check("mid_rst_drop_c", {16'b0, bus0.out_c}, 32'h0);
    check("mid_rst_count", {16'b0, cnt2}, 32'h0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 16'h0004, 16'h0000, 1'b1, 1'b1);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    check("mid_out_c", {16'b0, bus2.out_c}, 32'h0004);
    check("mid_out_valid", {31'b0, bus2.out_valid}, 32'h1);
    check("mid_beat_count", {16'b0, cnt2}, 32'h1);

    // beat_count wrap
    do_reset();
    drive(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1);
    repeat (65535) tick();
    check("wrap_ffff", {16'b0, cnt0}, 32'hFFFF);
    tick();
    check("wrap_zero", {16'b0, cnt0}, 32'h0000);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    check("wrap_one", {16'b0, cnt0}, 32'h0001);
    check("wrap_one_accum", {16'b0, cnt2}, 32'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
